// File: rtl/opa_cfg_pkg.sv
// Shared types and default sizing for the OPA configuration-chain loader.
package opa_cfg_pkg;

  localparam int unsigned WORD_W_DEF     = 32;
  localparam int unsigned NUM_WORDS_DEF  = 4;
  localparam int unsigned GAP_CYCLES_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_PH_B,
    ST_GAP_B,
    ST_PH_A,
    ST_GAP_A,
    ST_FINISH
  } state_t;

  // Counter width for a count range of 'range' values, never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/opa_phase_gen.sv
// Two-phase latch-enable sequencer: PH_B -> GAP_B -> PH_A -> GAP_A, with a
// step_done_c strobe on the last GAP_A cycle. Word/bit sequencing lives in the top.
module opa_phase_gen
  import opa_cfg_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic   CLK,
  input  logic   resetn,
  input  state_t state,
  input  state_t state_next,
  output state_t phase_next_c,
  output logic   step_done_c,
  output logic   ph_a,
  output logic   ph_b
);

  localparam int unsigned GAP_W = cnt_w(GAP_CYCLES);

  logic [GAP_W-1:0] gap_cnt;
  logic             in_gap_c;
  logic             gap_last_c;

  assign in_gap_c   = (state == ST_GAP_B) || (state == ST_GAP_A);
  assign gap_last_c = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  // Gap counter restarts at zero on every gap entry; enables follow the next state.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      gap_cnt <= '0;
      ph_a    <= 1'b0;
      ph_b    <= 1'b0;
    end else begin
      if (in_gap_c && !gap_last_c) gap_cnt <= gap_cnt + 1'b1;
      else                         gap_cnt <= '0;
      ph_a <= (state_next == ST_PH_A);
      ph_b <= (state_next == ST_PH_B);
    end
  end

  always_comb begin
    phase_next_c = state;
    step_done_c  = 1'b0;
    case (state)
      ST_PH_B:  phase_next_c = ST_GAP_B;
      ST_GAP_B: if (gap_last_c) phase_next_c = ST_PH_A;
      ST_PH_A:  phase_next_c = ST_GAP_A;
      ST_GAP_A: if (gap_last_c) step_done_c = 1'b1;
      default:  phase_next_c = state;
    endcase
  end

endmodule

// File: rtl/opa_config_loader.sv
// Serial loader for a two-phase OPA configuration latch chain, LSB first.
// Optional readback of the chain tail is enabled with macro OPA_CFG_READBACK_EN.
module opa_config_loader
  import opa_cfg_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned NUM_WORDS  = NUM_WORDS_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              conf_din,
  output logic              conf_ph_a,
  output logic              conf_ph_b,
  output logic              mode,
  output logic              busy,
  output logic              done
`ifdef OPA_CFG_READBACK_EN
  ,
  input  logic              conf_dout,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int unsigned BIT_W  = cnt_w(WORD_W);
  localparam int unsigned WORD_CW = cnt_w(NUM_WORDS);

  state_t state, state_next, phase_next_c;
  logic   step_done_c;
  logic   accept_c, last_bit_c, last_word_c, advance_c;

  logic [WORD_W-1:0]  shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WORD_CW-1:0] word_cnt;

  assign accept_c    = cfg_valid && cfg_ready;
  assign last_bit_c  = (bit_cnt == BIT_W'(WORD_W - 1));
  assign last_word_c = (word_cnt == WORD_CW'(NUM_WORDS - 1));
  assign advance_c   = (state == ST_GAP_A) && step_done_c;

  opa_phase_gen #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_phase_gen (
    .CLK         (CLK),
    .resetn      (resetn),
    .state       (state),
    .state_next  (state_next),
    .phase_next_c(phase_next_c),
    .step_done_c (step_done_c),
    .ph_a        (conf_ph_a),
    .ph_b        (conf_ph_b)
  );

  always_ff @(posedge CLK) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start) state_next = ST_WAIT_WORD;
      ST_WAIT_WORD: if (accept_c) state_next = ST_PH_B;
      ST_PH_B,
      ST_GAP_B,
      ST_PH_A:      state_next = phase_next_c;
      ST_GAP_A: begin
        if (step_done_c) begin
          if (!last_bit_c)       state_next = ST_PH_B;
          else if (!last_word_c) state_next = ST_WAIT_WORD;
          else                   state_next = ST_FINISH;
        end
      end
      ST_FINISH:    state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // shreg holds the bits still to be presented; conf_din changes only on PH_B entry.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      conf_din  <= 1'b0;
      cfg_ready <= 1'b0;
      mode      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_ready <= (state_next == ST_WAIT_WORD);
      busy      <= (state_next != ST_IDLE);
      done      <= (state_next == ST_FINISH);
      mode      <= (state_next != ST_IDLE) && (state_next != ST_FINISH);
      if ((state == ST_IDLE) && start) begin
        word_cnt <= '0;
        bit_cnt  <= '0;
      end
      if ((state == ST_WAIT_WORD) && accept_c) begin
        shreg    <= cfg_data >> 1;
        conf_din <= cfg_data[0];
        bit_cnt  <= '0;
      end
      if (advance_c) begin
        if (!last_bit_c) begin
          bit_cnt  <= bit_cnt + 1'b1;
          shreg    <= shreg >> 1;
          conf_din <= shreg[0];
        end else if (!last_word_c) begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

`ifdef OPA_CFG_READBACK_EN
  logic [WORD_W-1:0] rb_sh;
  logic [WORD_W-1:0] rb_shift_c;

  assign rb_shift_c = (rb_sh >> 1) | (WORD_W'(conf_dout) << (WORD_W - 1));

  // Chain tail is sampled once per bit step, on the last GAP_A cycle.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      rb_sh    <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (advance_c) begin
        rb_sh <= rb_shift_c;
        if (last_bit_c) begin
          rb_data  <= rb_shift_c;
          rb_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_opa_config_loader.sv
// Directed bench for opa_config_loader (WORD_W=4, NUM_WORDS=2, GAP_CYCLES=1).
module tb_opa_config_loader;

  localparam int unsigned W   = 4;
  localparam int unsigned NW  = 2;
  localparam int unsigned GAP = 1;

  logic         CLK = 1'b0;
  logic         resetn, start, cfg_valid;
  logic [W-1:0] cfg_data;
  logic         cfg_ready, conf_din, conf_ph_a, conf_ph_b, mode, busy, done;
`ifdef OPA_CFG_READBACK_EN
  logic         conf_dout;
  logic [W-1:0] rb_data;
  logic         rb_valid;
  logic [3:0]   chain = 4'h0;
  int           rb_cnt = 0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0, last_pulse = -100, pulse_total = 0, overlap_err = 0, gap_err = 0;

  always #5 CLK = ~CLK;

  opa_config_loader #(.WORD_W(W), .NUM_WORDS(NW), .GAP_CYCLES(GAP)) u_dut (
    .CLK      (CLK),
    .resetn   (resetn),
    .start    (start),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .conf_din (conf_din),
    .conf_ph_a(conf_ph_a),
    .conf_ph_b(conf_ph_b),
    .mode     (mode),
    .busy     (busy),
    .done     (done)
`ifdef OPA_CFG_READBACK_EN
    ,
    .conf_dout(conf_dout),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
`endif
  );

`ifdef OPA_CFG_READBACK_EN
  assign conf_dout = chain[3];
  always @(posedge CLK) begin
    if (conf_ph_a) chain <= {chain[2:0], conf_din};
    if (rb_valid) rb_cnt++;
  end
`endif

  // Continuous enable-overlap and gap monitor.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (conf_ph_a && conf_ph_b) overlap_err++;
    if (conf_ph_a || conf_ph_b) begin
      if (cyc - last_pulse <= int'(GAP)) gap_err++;
      last_pulse = cyc;
      pulse_total++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame with cfg_valid held high, optional stall before word 2,
  // optional start pokes while busy and on the done cycle.
  task automatic run_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input int stall, input bit poke,
                           output int done_n, output logic [7:0] pa_bits,
                           output logic [7:0] pb_bits, output int pa_n,
                           output int stall_bad, output int dones);
    int widx, left, pb_n;
    bit acc, stalled;
    widx = 0; left = stall; done_n = -1; pa_n = 0; pb_n = 0;
    stall_bad = 0; dones = 0; pa_bits = '0; pb_bits = '0;
    start = 1'b1;
    for (int n = 1; n <= 200 && done_n < 0; n++) begin
      cfg_data  = (widx == 0) ? w0 : w1;
      cfg_valid = 1'b1;
      stalled   = 1'b0;
      if (widx == 1 && cfg_ready && left > 0) begin
        cfg_valid = 1'b0;
        stalled   = 1'b1;
        left--;
      end
      acc = cfg_valid && cfg_ready;
      if (poke && n == 5) start = 1'b1;
      tick();
      start = 1'b0;
      if (acc) widx++;
      if (n == 1) chk("mode_wait", 32'(mode), 32'd1);
      if (stalled && (!cfg_ready || conf_ph_a || conf_ph_b || conf_din !== w0[W-1]))
        stall_bad++;
      if (conf_ph_a) begin
        if (pa_n < 8) pa_bits[pa_n] = conf_din;
        pa_n++;
      end
      if (conf_ph_b) begin
        if (pb_n < 8) pb_bits[pb_n] = conf_din;
        pb_n++;
      end
      if (done) begin
        done_n = n;
        dones++;
        chk("mode_done", 32'(mode), 32'd0);
      end
    end
    if (poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (done) dones++;
      end
      chk("idle_after_poke", 32'(busy), 32'd0);
    end
  endtask

  int          done_n, pa_n, stall_bad, dones, p0;
  logic [7:0]  pa_bits, pb_bits;

  initial begin
    resetn = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_din", 32'(conf_din), 32'd0);
    chk("rst_pha", 32'(conf_ph_a), 32'd0);
    chk("rst_phb", 32'(conf_ph_b), 32'd0);
    resetn = 1'b1;
    tick();

    // Frame A: 1011 then 0110; 2*(1+4*4)+1 = 35 cycles to done.
    run_frame(4'b1011, 4'b0110, 0, 1'b0, done_n, pa_bits, pb_bits, pa_n, stall_bad, dones);
    chk("a_done_cyc", 32'(done_n), 32'd35);
    chk("a_pa_bits", 32'(pa_bits), 32'h6B);
    chk("a_pb_bits", 32'(pb_bits), 32'h6B);
    chk("a_pa_count", 32'(pa_n), 32'd8);
    chk("a_dones", 32'(dones), 32'd1);
`ifdef OPA_CFG_READBACK_EN
    chk("a_rb_count", 32'(rb_cnt), 32'd2);
`endif
    repeat (3) tick();

    // Frame B: 10-cycle stall before word 2 stretches the frame to 45.
    run_frame(4'b0011, 4'b1100, 10, 1'b0, done_n, pa_bits, pb_bits, pa_n, stall_bad, dones);
    chk("b_done_cyc", 32'(done_n), 32'd45);
    chk("b_pa_bits", 32'(pa_bits), 32'hC3);
    chk("b_stall_bad", 32'(stall_bad), 32'd0);
    chk("b_dones", 32'(dones), 32'd1);
    repeat (3) tick();

    // Reset on the second PH_A pulse aborts with no further enables.
    start = 1'b1; cfg_valid = 1'b1; cfg_data = 4'b1001;
    pa_n = 0;
    for (int n = 0; n < 60 && pa_n < 2; n++) begin
      tick();
      start = 1'b0;
      if (conf_ph_a) pa_n++;
    end
    chk("r_reached_pha2", 32'(pa_n), 32'd2);
    resetn = 1'b0;
    tick();
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_mode", 32'(mode), 32'd0);
    chk("r_din", 32'(conf_din), 32'd0);
    chk("r_pha", 32'(conf_ph_a), 32'd0);
    chk("r_phb", 32'(conf_ph_b), 32'd0);
    chk("r_ready", 32'(cfg_ready), 32'd0);
    chk("r_done", 32'(done), 32'd0);
    p0 = pulse_total;
    resetn = 1'b1;
    repeat (6) tick();
    chk("r_no_pulses", 32'(pulse_total - p0), 32'd0);
    chk("r_idle", 32'(busy), 32'd0);
    run_frame(4'b1111, 4'b0001, 0, 1'b0, done_n, pa_bits, pb_bits, pa_n, stall_bad, dones);
    chk("c_done_cyc", 32'(done_n), 32'd35);
    chk("c_pa_bits", 32'(pa_bits), 32'h1F);
    repeat (3) tick();

    // Start pulses while busy and on the done cycle are ignored.
    run_frame(4'b0101, 4'b1010, 0, 1'b1, done_n, pa_bits, pb_bits, pa_n, stall_bad, dones);
    chk("d_done_cyc", 32'(done_n), 32'd35);
    chk("d_pa_bits", 32'(pa_bits), 32'hA5);
    chk("d_dones", 32'(dones), 32'd1);

    chk("mon_overlap", 32'(overlap_err), 32'd0);
    chk("mon_gap", 32'(gap_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
